// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use / long-op hazard stall, and a single-entry
// long-latency scoreboard with saturating stall accounting.
module fwd_hazard_unit #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NSRC = 2,
  parameter int unsigned LAT  = 4,
  localparam int unsigned SELW = $clog2(NSRC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      rs_id,
  input  logic [AW-1:0]      rt_id,
  input  logic [AW-1:0]      rs_ex,
  input  logic [AW-1:0]      rt_ex,
  input  logic               ex_regwrite,
  input  logic               ex_is_load,
  input  logic [AW-1:0]      ex_wr_addr,
  input  logic [NSRC-1:0]    src_we,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic               long_issue,
  input  logic [AW-1:0]      long_dst,
  output logic [SELW-1:0]    fwd_a,
  output logic [SELW-1:0]    fwd_b,
  output logic               stall,
  output logic               long_busy,
  output logic               long_done,
  output logic [AW-1:0]      long_wb_addr,
  output logic               err_overlap,
  output logic [15:0]        stall_cnt
);

  localparam int unsigned CW = 4;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          stateQ, stateD;
  logic [CW-1:0]   cntQ, cntD;
  logic [AW-1:0]   dstQ, dstD;
  logic [AW-1:0]   wbQ, wbD;
  logic            doneQ, doneD;
  logic            errQ, errD;
  logic [15:0]     stallCntQ, stallCntD;
  logic            loadUse, longHaz;

  // Walk oldest to nearest so the nearest matching stage wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_we[i] && (src_addr[i*AW +: AW] != '0)) begin
        if (src_addr[i*AW +: AW] == rs_ex) fwd_a = SELW'(i + 1);
        if (src_addr[i*AW +: AW] == rt_ex) fwd_b = SELW'(i + 1);
      end
    end
  end

  assign loadUse = ex_is_load && ex_regwrite && (ex_wr_addr != '0) &&
                   ((ex_wr_addr == rs_id) || (ex_wr_addr == rt_id));
  assign longHaz = long_busy && (dstQ != '0) && ((dstQ == rs_id) || (dstQ == rt_id));
  assign stall   = loadUse || longHaz;

  assign long_busy    = (stateQ == StBusy);
  assign long_done    = doneQ;
  assign long_wb_addr = wbQ;
  assign err_overlap  = errQ;
  assign stall_cnt    = stallCntQ;

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    dstD      = dstQ;
    wbD       = wbQ;
    doneD     = 1'b0;
    errD      = errQ || (long_issue && (stateQ == StBusy));
    stallCntD = (stall && (stallCntQ != 16'hFFFF)) ? stallCntQ + 16'd1 : stallCntQ;
    unique case (stateQ)
      StIdle: begin
        if (long_issue) begin
          stateD = StBusy;
          dstD   = long_dst;
          cntD   = CW'(LAT - 1);
        end
      end
      StBusy: begin
        if (cntQ == '0) begin
          stateD = StIdle;
          doneD  = 1'b1;
          wbD    = dstQ;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= StIdle;
      cntQ      <= '0;
      dstQ      <= '0;
      wbQ       <= '0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      stallCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      dstQ      <= dstD;
      wbQ       <= wbD;
      doneQ     <= doneD;
      errQ      <= errD;
      stallCntQ <= stallCntD;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with default parameters (AW=5, NSRC=2, LAT=4).
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_id, rt_id, rs_ex, rt_ex, ex_wr_addr, long_dst;
  logic        ex_regwrite, ex_is_load, long_issue;
  logic [1:0]  src_we;
  logic [9:0]  src_addr;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, long_busy, long_done, err_overlap;
  logic [4:0]  long_wb_addr;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .rs_id       (rs_id),
    .rt_id       (rt_id),
    .rs_ex       (rs_ex),
    .rt_ex       (rt_ex),
    .ex_regwrite (ex_regwrite),
    .ex_is_load  (ex_is_load),
    .ex_wr_addr  (ex_wr_addr),
    .src_we      (src_we),
    .src_addr    (src_addr),
    .long_issue  (long_issue),
    .long_dst    (long_dst),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .long_busy   (long_busy),
    .long_done   (long_done),
    .long_wb_addr(long_wb_addr),
    .err_overlap (err_overlap),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; a "cycle" runs from here to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {rs_id, rt_id, rs_ex, rt_ex, ex_wr_addr, long_dst} = '0;
    {ex_regwrite, ex_is_load, long_issue} = '0;
    src_we = '0;
    src_addr = '0;
    tick();
    tick();
    chk("rst_busy", 32'(long_busy), 32'd0);
    chk("rst_done", 32'(long_done), 32'd0);
    chk("rst_wb", 32'(long_wb_addr), 32'd0);
    chk("rst_err", 32'(err_overlap), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Forwarding and load-use remain live while reset is held.
    src_we = 2'b01; src_addr = {5'd0, 5'd7}; rs_ex = 5'd7;
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_wr_addr = 5'd6; rs_id = 5'd6;
    #1;
    chk("rst_fwd_a", 32'(fwd_a), 32'd1);
    chk("rst_stall_lu", 32'(stall), 32'd1);
    tick();
    chk("rst_scnt_hold", 32'(stall_cnt), 32'd0);
    src_we = '0; src_addr = '0; rs_ex = '0;
    ex_is_load = 1'b0; ex_regwrite = 1'b0; ex_wr_addr = '0; rs_id = '0;
    reset = 1'b0;
    tick();

    // Forwarding priority.
    src_we = 2'b11; src_addr = {5'd8, 5'd8}; rs_ex = 5'd8; rt_ex = 5'd8;
    #1;
    chk("fwd_a_mem", 32'(fwd_a), 32'd1);
    chk("fwd_b_mem", 32'(fwd_b), 32'd1);
    src_we = 2'b10;
    #1;
    chk("fwd_a_wb", 32'(fwd_a), 32'd2);
    src_we = 2'b11; src_addr = {5'd0, 5'd0}; rs_ex = 5'd0;
    #1;
    chk("fwd_a_r0", 32'(fwd_a), 32'd0);
    src_addr = {5'd5, 5'd6}; rt_ex = 5'd5; rs_ex = 5'd6;
    #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'd2);
    chk("fwd_a_mem2", 32'(fwd_a), 32'd1);
    src_we = 2'b00;
    #1;
    chk("fwd_none", 32'(fwd_a), 32'd0);
    src_addr = '0; rs_ex = '0; rt_ex = '0;

    // Load-use hazard.
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_wr_addr = 5'd9; rt_id = 5'd9;
    #1;
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    chk("lu_scnt", 32'(stall_cnt), 32'd1);
    ex_wr_addr = 5'd0;
    #1;
    chk("lu_r0", 32'(stall), 32'd0);
    ex_wr_addr = 5'd9; ex_regwrite = 1'b0;
    #1;
    chk("lu_nowr", 32'(stall), 32'd0);
    tick();
    chk("lu_scnt_hold", 32'(stall_cnt), 32'd1);
    ex_is_load = 1'b0; ex_wr_addr = '0; rt_id = '0;

    // Long op: issue in cycle 0, overlap in cycle 2, reissue in cycle 5.
    rs_id = 5'd3; long_issue = 1'b1; long_dst = 5'd3;
    #1;
    chk("lo_c0_busy", 32'(long_busy), 32'd0);
    tick();  // cycle 1
    long_issue = 1'b0;
    chk("lo_c1_busy", 32'(long_busy), 32'd1);
    chk("lo_c1_stall", 32'(stall), 32'd1);
    tick();  // cycle 2
    long_issue = 1'b1; long_dst = 5'd7;
    chk("lo_c2_stall", 32'(stall), 32'd1);
    chk("lo_c2_err", 32'(err_overlap), 32'd0);
    tick();  // cycle 3
    long_issue = 1'b0;
    chk("lo_c3_err", 32'(err_overlap), 32'd1);
    chk("lo_c3_stall", 32'(stall), 32'd1);
    tick();  // cycle 4
    chk("lo_c4_stall", 32'(stall), 32'd1);
    chk("lo_c4_done", 32'(long_done), 32'd0);
    tick();  // cycle 5
    chk("lo_c5_done", 32'(long_done), 32'd1);
    chk("lo_c5_wb", 32'(long_wb_addr), 32'd3);
    chk("lo_c5_stall", 32'(stall), 32'd0);
    chk("lo_c5_busy", 32'(long_busy), 32'd0);
    chk("lo_c5_scnt", 32'(stall_cnt), 32'd5);
    long_issue = 1'b1; long_dst = 5'd12;
    tick();  // cycle 6
    long_issue = 1'b0;
    chk("lo_c6_done", 32'(long_done), 32'd0);
    chk("lo_c6_wbhold", 32'(long_wb_addr), 32'd3);
    chk("lo_c6_busy", 32'(long_busy), 32'd1);
    chk("lo_c6_stall", 32'(stall), 32'd0);
    tick();
    tick();
    tick();  // cycle 9
    chk("lo_c9_busy", 32'(long_busy), 32'd1);
    chk("lo_c9_done", 32'(long_done), 32'd0);
    tick();  // cycle 10
    chk("lo_c10_done", 32'(long_done), 32'd1);
    chk("lo_c10_wb", 32'(long_wb_addr), 32'd12);
    chk("lo_c10_err", 32'(err_overlap), 32'd1);
    chk("lo_c10_scnt", 32'(stall_cnt), 32'd5);
    tick();
    chk("lo_c11_done", 32'(long_done), 32'd0);

    // Reset aborts an in-flight op.
    rs_id = 5'd4; long_issue = 1'b1; long_dst = 5'd4;
    tick();  // cycle 1
    long_issue = 1'b0;
    chk("ab_c1_stall", 32'(stall), 32'd1);
    tick();  // cycle 2
    reset = 1'b1;
    tick();  // cycle 3
    reset = 1'b0;
    chk("ab_busy", 32'(long_busy), 32'd0);
    chk("ab_scnt", 32'(stall_cnt), 32'd0);
    chk("ab_err", 32'(err_overlap), 32'd0);
    chk("ab_wb", 32'(long_wb_addr), 32'd0);
    chk("ab_stall", 32'(stall), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("ab_nodone", 32'(long_done), 32'd0);
      tick();
    end
    rs_id = '0;

    // Saturation of the stall counter.
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_wr_addr = 5'd9; rt_id = 5'd9;
    repeat (65534) tick();
    chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (5) tick();
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter AW, default 5: register address width.
REQ-002 Parameter NSRC, default 2: number of forwarding source stages; index 0 is nearest to EX (MEM), index NSRC-1 is oldest (WB).
REQ-003 Parameter LAT, default 4: long-op latency in cycles, legal range 2..15.
REQ-004 Derived SELW = $clog2(NSRC+1): width of the forwarding select fields.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rs_id, rt_id  in  AW  source register addresses of the instruction in ID.
REQ-008 rs_ex, rt_ex  in  AW  source register addresses of the instruction in EX.
REQ-009 ex_regwrite, ex_is_load  in  1  EX instruction writes a register / is a load.
REQ-010 ex_wr_addr  in  AW  destination register of the EX instruction.
REQ-011 src_we  in  NSRC  per-stage RegWrite, bit i = stage i.
REQ-012 src_addr  in  NSRC*AW  per-stage write address; bits [i*AW +: AW] = stage i.
REQ-013 long_issue  in  1  long-latency op (mul/div) issues from EX this cycle.
REQ-014 long_dst  in  AW  destination register of the issuing long op.
REQ-015 fwd_a, fwd_b  out  SELW  operand select: 0 = register file, i+1 = stage i.
REQ-016 stall  out  1  hold PC and IF/ID, bubble into EX.
REQ-017 long_busy  out  1  long op in flight.
REQ-018 long_done, long_wb_addr  out  1, AW  one-cycle writeback strobe and destination of the completed long op.
REQ-019 err_overlap  out  1  sticky: long_issue was received while long_busy was high.
REQ-020 stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-021 fwd_a SHALL be combinational: i+1 for the lowest i with src_we[i]=1, slice i != 0, and slice i == rs_ex; otherwise 0 (nearest stage has priority).
REQ-022 fwd_b SHALL follow the same rule against rt_ex.
REQ-023 Load-use hazard SHALL be ex_is_load & ex_regwrite & ex_wr_addr != 0 & (ex_wr_addr == rs_id | ex_wr_addr == rt_id).
REQ-024 Long hazard SHALL be long_busy & dst_reg != 0 & (dst_reg == rs_id | dst_reg == rt_id), where dst_reg is the captured long_dst.
REQ-025 stall SHALL be combinational: load-use OR long hazard.
REQ-026 Scoreboard states:
- IDLE (long_busy=0) -> BUSY on long_issue: capture dst_reg=long_dst, cnt=LAT-1.
- BUSY: cnt decrements each cycle.
- BUSY with cnt==0 -> IDLE, with long_done=1 and long_wb_addr=dst_reg in the following cycle only.
REQ-027 Issue sampled at the end of cycle T SHALL give long_busy=1 in cycles T+1..T+LAT and long_done=1 in cycle T+LAT+1.
REQ-028 In the long_done cycle no long hazard SHALL be raised; the register file writes before it is read.
REQ-029 long_issue while long_busy=1 SHALL be ignored: dst_reg and cnt are unchanged and err_overlap is set.
REQ-030 long_issue in the long_done cycle SHALL be accepted, since long_busy=0 then.
REQ-031 stall_cnt SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.
REQ-032 long_wb_addr SHALL hold its last value when long_done=0.

Reset
REQ-033 On reset: long_busy=0, long_done=0, long_wb_addr=0, dst_reg=0, cnt=0, err_overlap=0, stall_cnt=0.
REQ-034 Reset SHALL abort an in-flight long op with no long_done pulse; fwd_a, fwd_b and load-use stall stay combinationally valid during reset.

Verification
REQ-035 src_we=2'b11, both slices=5'd8, rs_ex=8 -> fwd_a=1; clear src_we[0] -> fwd_a=2; rs_ex=0 with slice=0 -> fwd_a=0.
REQ-036 ex_is_load=1, ex_regwrite=1, ex_wr_addr=9, rt_id=9 -> stall=1 and stall_cnt +1; ex_wr_addr=0 -> stall=0.
REQ-037 LAT=4, long_issue with long_dst=3 at cycle 0, rs_id=3 held -> stall=1 in cycles 1..4; long_done=1 with long_wb_addr=3 and stall=0 in cycle 5.
REQ-038 Second long_issue in cycle 2 -> ignored, err_overlap=1, long_done still in cycle 5; new issue in cycle 5 -> long_done in cycle 10.
REQ-039 Reset asserted in cycle 2 of a long op -> long_busy=0 next cycle, no long_done, stall_cnt=0.
REQ-040 Stall held 65540 cycles -> stall_cnt=16'hFFFF and stays there.
